b_bop_iter: RTL and testbench

B_BOP_ITER -- requirements
Module: b_bop_iter

---
 rtl/b_bop_iter.sv | 158 +++++++++++++++
 tb/tb_b_bop_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/b_bop_iter.sv
// rtl/b_bop_iter.sv - iterative bitwise 3-input LUT operator with pass feedback
//
// Purpose:
//   Applies an 8-entry truth table bit-by-bit to three operand vectors
//   (rd, rs1, rs2), SLICE bits per cycle. The result is fed back as rd and
//   the table is applied again, for "passes" passes in total.
//
// Ports:
//   g_clk      - clock, rising edge
//   g_resetn   - asynchronous active-low reset
//   in_valid   - request present
//   in_ready   - high in IDLE; request taken on in_valid && in_ready
//   rd/rs1/rs2 - WIDTH-bit operands
//   lut        - truth table, output bit = lut[{rd[i], rs2[i], rs1[i]}]
//   passes     - number of LUT applications (0 returns rd unchanged)
//   flush      - synchronous abort, wins over accept and complete
//   out_valid  - high in DONE
//   out_ready  - result consumed on out_valid && out_ready
//   result     - working register contents

module b_bop_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int PW    = 4
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [7:0]       lut,
    input  logic [PW-1:0]    passes,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("b_bop_iter: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    localparam int NSL = WIDTH / SLICE;
    localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_rs1;
    logic [WIDTH-1:0] r_rs2;
    logic [7:0]       r_lut;
    logic [SW-1:0]    r_s;
    logic [PW-1:0]    r_p;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;
    logic             w_accept;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_acc;
    assign w_last    = (r_s == S_LAST);
    assign w_accept  = in_valid && (r_state == IDLE);

    // Only the slice selected by r_s is rewritten; other slices keep the
    // value from the previous pass, so each bit sees its own prior result.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < NSL; k++) begin
            if (r_s == SW'(k)) begin
                for (int j = 0; j < SLICE; j++) begin
                    w_acc_nxt[k*SLICE + j] =
                        r_lut[{r_acc[k*SLICE + j], r_rs2[k*SLICE + j], r_rs1[k*SLICE + j]}];
                end
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = (passes != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    // r_p is at least 1 in RUN; the last slice of the last pass ends the run
                    if (w_last && r_p <= PW'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_acc <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_lut <= '0;
            r_s   <= '0;
            r_p   <= '0;
        end else if (flush) begin
            r_acc <= '0;
            r_s   <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_acc <= rd;
            r_rs1 <= rs1;
            r_rs2 <= rs2;
            r_lut <= lut;
            r_s   <= '0;
            r_p   <= passes;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_s <= '0;
                // Count down only while more passes remain, so an all-ones
                // pass count never wraps.
                if (r_p > PW'(1)) begin
                    r_p <= r_p - PW'(1);
                end
            end else begin
                r_s <= r_s + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_b_bop_iter.sv
// tb/tb_b_bop_iter.sv - table-driven bench for b_bop_iter at SLICE 1, 8 and 32
module tb_b_bop_iter;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        in_valid;
    logic [31:0] rd, rs1, rs2;
    logic [7:0]  lut;
    logic [3:0]  passes;
    logic        flush;
    logic        out_ready;

    logic [2:0]  w_in_ready;
    logic [2:0]  w_out_valid;
    logic [31:0] w_res [3];

    int total = 0;
    int bad   = 0;

    always #5 g_clk = ~g_clk;

    b_bop_iter #(.WIDTH(32), .SLICE(1), .PW(4)) u_s1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .in_valid(in_valid), .in_ready(w_in_ready[0]),
        .rd(rd), .rs1(rs1), .rs2(rs2), .lut(lut), .passes(passes), .flush(flush),
        .out_valid(w_out_valid[0]), .out_ready(out_ready), .result(w_res[0]));

    b_bop_iter #(.WIDTH(32), .SLICE(8), .PW(4)) u_s8 (
        .g_clk(g_clk), .g_resetn(g_resetn), .in_valid(in_valid), .in_ready(w_in_ready[1]),
        .rd(rd), .rs1(rs1), .rs2(rs2), .lut(lut), .passes(passes), .flush(flush),
        .out_valid(w_out_valid[1]), .out_ready(out_ready), .result(w_res[1]));

    b_bop_iter #(.WIDTH(32), .SLICE(32), .PW(4)) u_s32 (
        .g_clk(g_clk), .g_resetn(g_resetn), .in_valid(in_valid), .in_ready(w_in_ready[2]),
        .rd(rd), .rs1(rs1), .rs2(rs2), .lut(lut), .passes(passes), .flush(flush),
        .out_valid(w_out_valid[2]), .out_ready(out_ready), .result(w_res[2]));

    typedef struct {
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [7:0]  lut;
        logic [3:0]  passes;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];
    int   nsl [3] = '{32, 4, 1};
    int   lat [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [7:0] t,
                                          input int np);
        logic [31:0] acc;
        acc = a;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < 32; i++) begin
                acc[i] = t[{acc[i], c[i], b[i]}];
            end
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Present a request and let the acceptance edge pass.
    task automatic start(input vec_t v);
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; lut = v.lut; passes = v.passes;
        in_valid = 1'b1;
        out_ready = 1'b0;
        chk("in_ready_before_accept", {29'd0, w_in_ready}, 32'h7);
        tick();
        in_valid = 1'b0;
        // Disturb operands: they must be ignored outside IDLE.
        rd = ~v.rd; rs1 = ~v.rs1; rs2 = ~v.rs2; lut = ~v.lut; passes = ~v.passes;
    endtask

    // Wait (bounded) until every instance reaches DONE, recording latencies.
    task automatic wait_done(input vec_t v, input string tag);
        int cyc;
        int exp_lat;
        lat = '{0, 0, 0};
        cyc = 0;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && cyc < 600) begin
            tick();
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (w_out_valid[i] && lat[i] == 0) lat[i] = cyc;
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_lat = (v.passes == 0) ? 1 : int'(v.passes) * nsl[i];
            chk($sformatf("%s_lat_s%0d", tag, 32 / nsl[i]), lat[i], exp_lat);
            chk($sformatf("%s_model_s%0d", tag, 32 / nsl[i]), w_res[i],
                model(v.rd, v.rs1, v.rs2, v.lut, int'(v.passes)));
        end
        chk({tag, "_table_s8"}, w_res[1], v.exp);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, {29'd0, w_out_valid}, 32'h0);
        chk({tag, "_idle_in_ready"}, {29'd0, w_in_ready}, 32'h7);
    endtask

    initial begin
        logic [31:0] held;

        tbl[0] = '{32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF, 8'h96, 4'd1, 32'hF00F0FF0};
        tbl[1] = '{32'h12345678, 32'h0, 32'h0, 8'h0F, 4'd3, 32'hEDCBA987};
        tbl[2] = '{32'h12345678, 32'h0, 32'h0, 8'h0F, 4'd2, 32'h12345678};
        tbl[3] = '{32'hA5A5A5A5, 32'h0, 32'h0, 8'h00, 4'd0, 32'hA5A5A5A5};
        tbl[4] = '{32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF, 8'hE8, 4'd1, 32'h0FFF000F};
        tbl[5] = '{32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 8'hF0, 4'd15, 32'hDEADBEEF};
        tbl[6] = '{32'h00000000, 32'h13579BDF, 32'h0, 8'hAA, 4'd1, 32'h13579BDF};
        tbl[7] = '{32'hFFFFFFFF, 32'h0, 32'hCAFEF00D, 8'hCC, 4'd1, 32'hCAFEF00D};
        tbl[8] = '{32'hFFFFFFFF, 32'h0, 32'h0, 8'h00, 4'd2, 32'h00000000};
        tbl[9] = '{32'h0000FFFF, 32'h0, 32'h0, 8'h0F, 4'd15, 32'hFFFF0000};

        g_resetn = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0; lut = '0; passes = '0;
        #12;
        chk("rst_in_ready", {29'd0, w_in_ready}, 32'h7);
        chk("rst_out_valid", {29'd0, w_out_valid}, 32'h0);
        chk("rst_result_s8", w_res[1], 32'h0);
        tick();
        g_resetn = 1'b1;

        for (int n = 0; n < 10; n++) begin
            start(tbl[n]);
            wait_done(tbl[n], $sformatf("vec%0d", n));
            release_out($sformatf("vec%0d", n));
        end

        // Backpressure: hold in DONE with a pending new request.
        start(tbl[0]);
        wait_done(tbl[0], "bp");
        held = w_res[1];
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_out_valid_%0d", k), {31'd0, w_out_valid[1]}, 32'h1);
            chk($sformatf("bp_in_ready_%0d", k), {31'd0, w_in_ready[1]}, 32'h0);
            chk($sformatf("bp_result_%0d", k), w_res[1], held);
        end
        in_valid = 1'b0;
        release_out("bp");

        // Flush during the second RUN cycle.
        start(tbl[1]);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready", {29'd0, w_in_ready}, 32'h7);
        chk("flush_out_valid", {29'd0, w_out_valid}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("flush_quiet_%0d", k), {29'd0, w_out_valid}, 32'h0);
        end
        start(tbl[4]);
        wait_done(tbl[4], "post_flush");
        release_out("post_flush");

        // Asynchronous reset in the middle of a run.
        start(tbl[5]);
        tick();
        tick();
        #2;
        g_resetn = 1'b0;
        #1;
        chk("arst_in_ready", {29'd0, w_in_ready}, 32'h7);
        chk("arst_out_valid", {29'd0, w_out_valid}, 32'h0);
        chk("arst_result_s8", w_res[1], 32'h0);
        tick();
        chk("arst_hold_out_valid", {29'd0, w_out_valid}, 32'h0);
        g_resetn = 1'b1;
        start(tbl[0]);
        wait_done(tbl[0], "post_rst");
        release_out("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
